// File: rtl/mdio_mgmt_responder.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO, serves register reads, reports writes.
// MDIO drive changes land <=4 clk after the MDC pin falls; no backpressure, the SMI master sets the pace.
module mdio_mgmt_responder #(
  parameter int          NUM_REGS     = 16,
  parameter logic [15:0] PHY_ID1      = 16'h0180,
  parameter logic [15:0] PHY_ID2      = 16'hDD00,
  parameter logic [15:0] CTRL_RESET   = 16'h1140,
  parameter int          PREAMBLE_MIN = 32,
  parameter int          TIMEOUT_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  phy_addr,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic [15:0] status_in,
  output logic [15:0] ctrl_reg,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy
);

  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);
  localparam logic [5:0]    PRE_MIN   = 6'(PREAMBLE_MIN);
  localparam logic [5:0]    REG_LIM   = 6'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_COMMIT
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    mdc_sync, mdio_sync;
  logic          mdc_q;
  logic          rise, fall, bit_in, timeout, stored;
  logic [5:0]    pre_cnt;
  logic [4:0]    bit_cnt, regad, shift5;
  logic [1:0]    shift2;
  logic [15:0]   in_sr, rd_sr, rdata;
  logic          is_read;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   regs [32];

  assign rise    = mdc_sync[1] & ~mdc_q;
  assign fall    = ~mdc_sync[1] & mdc_q;
  assign bit_in  = mdio_sync[1];
  assign shift2  = {in_sr[0], bit_in};
  assign shift5  = {in_sr[3:0], bit_in};
  assign timeout = (state != S_IDLE) && (tmo_cnt == TMO_LIMIT);
  assign stored  = ({1'b0, regad} >= 6'd4) && ({1'b0, regad} < REG_LIM);
  assign busy    = (state != S_IDLE);

  always_comb begin
    rdata = 16'h0000;
    case (regad)
      5'd0:    rdata = ctrl_reg;
      5'd1:    rdata = status_in;
      5'd2:    rdata = PHY_ID1;
      5'd3:    rdata = PHY_ID2;
      default: if (stored) rdata = regs[regad];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (rise && !bit_in && pre_cnt >= PRE_MIN) state_nxt = S_ST2;
        S_ST2:    if (rise) state_nxt = bit_in ? S_OP : S_IDLE;
        S_OP:     if (rise && bit_cnt == 5'd1)
                    state_nxt = (shift2 == 2'b10 || shift2 == 2'b01) ? S_PHYAD : S_IDLE;
        S_PHYAD:  if (rise && bit_cnt == 5'd4)
                    state_nxt = (shift5 == phy_addr) ? S_REGAD : S_IDLE;
        S_REGAD:  if (rise && bit_cnt == 5'd4) state_nxt = S_TA;
        S_TA: begin
          if (rise) begin
            if (is_read)                state_nxt = S_DATA;
            else if (bit_cnt == 5'd1)   state_nxt = (shift2 == 2'b10) ? S_DATA : S_IDLE;
          end
        end
        S_DATA: begin
          if (is_read) begin
            if (fall && bit_cnt == 5'd16) state_nxt = S_IDLE;
          end else if (rise && bit_cnt == 5'd15) begin
            state_nxt = S_COMMIT;
          end
        end
        S_COMMIT: state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_q     <= 1'b0;
      tmo_cnt   <= '0;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      in_sr     <= '0;
      rd_sr     <= '0;
      regad     <= '0;
      is_read   <= 1'b0;
      mdio_out  <= 1'b0;
      mdio_oe   <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      ctrl_reg  <= CTRL_RESET;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdio_sync <= {mdio_sync[0], mdio_in};
      mdc_q     <= mdc_sync[1];
      tmo_cnt   <= (state == S_IDLE || rise) ? '0 : tmo_cnt + 1'b1;

      // Preamble only accumulates while idle, so every frame needs a fresh one.
      if (state != S_IDLE) pre_cnt <= '0;
      else if (rise)       pre_cnt <= !bit_in ? '0 : ((pre_cnt == 6'h3F) ? pre_cnt : pre_cnt + 1'b1);

      if (state_nxt != state) bit_cnt <= '0;
      else if (rise)          bit_cnt <= bit_cnt + 1'b1;

      if (rise) in_sr <= {in_sr[14:0], bit_in};
      if (state == S_OP && rise && bit_cnt == 5'd1)    is_read <= (shift2 == 2'b10);
      if (state == S_REGAD && rise && bit_cnt == 5'd4) regad   <= shift5;

      if (timeout) begin
        mdio_oe  <= 1'b0;
        mdio_out <= 1'b0;
      end else if (state == S_TA && is_read && fall) begin
        mdio_oe  <= 1'b1;
        mdio_out <= 1'b0;
        rd_sr    <= rdata;
      end else if (state == S_DATA && is_read && fall) begin
        if (bit_cnt == 5'd16) begin
          mdio_oe  <= 1'b0;
          mdio_out <= 1'b0;
        end else begin
          mdio_out <= rd_sr[15];
          rd_sr    <= {rd_sr[14:0], 1'b0};
        end
      end

      wr_valid <= 1'b0;
      if (state == S_COMMIT) begin
        wr_valid <= 1'b1;
        wr_addr  <= regad;
        wr_data  <= in_sr;
        // Soft-reset bit self-clears, but the notification still carries what was written.
        if (regad == 5'd0) ctrl_reg     <= {1'b0, in_sr[14:0]};
        else if (stored)   regs[regad]  <= in_sr;
      end
    end
  end

endmodule
